// File: rtl/pio_v2_pkg.sv
// Shared constants for the edge-interrupt PIO: register word addresses and parameter limits.
package pio_v2_pkg;

  localparam int WIDTH_MIN       = 1;
  localparam int WIDTH_MAX       = 32;
  localparam int SYNC_STAGES_MIN = 2;
  localparam int SYNC_STAGES_MAX = 3;

  typedef enum logic [2:0] {
    ADDR_DATA_IN      = 3'd0,
    ADDR_DATA_OUT     = 3'd1,
    ADDR_IRQ_MASK     = 3'd2,
    ADDR_EDGE_CAPTURE = 3'd3,
    ADDR_RISE_EN      = 3'd4,
    ADDR_FALL_EN      = 3'd5,
    ADDR_OUT_SET      = 3'd6,
    ADDR_OUT_CLR      = 3'd7
  } addr_e;

endpackage

// File: rtl/pio_bit_sync.sv
// One input bit: synchronizer, optional debounce filter (PIO_DEBOUNCE_EN) and the prev flop
// used for edge detection.
module pio_bit_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
`ifdef PIO_DEBOUNCE_EN
  input  logic tick,
`endif
  output logic filt,
  output logic prev
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic                   prev_q;

  // NOTE: every flop here uses <= so all stages advance together on the same edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], din};
  end

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef PIO_DEBOUNCE_EN
  logic last_q;
  logic filt_q;

  // Accept a new level only after two consecutive ticks agree on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= 1'b0;
      filt_q <= 1'b0;
    end else if (tick) begin
      last_q <= synced;
      if (synced == last_q) filt_q <= synced;
    end
  end

  assign filt = filt_q;
`else
  assign filt = synced;
`endif

  // prev resets to the same value as filt, so leaving reset never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prev_q <= 1'b0;
    else          prev_q <= filt;
  end

  assign prev = prev_q;

endmodule

// File: rtl/pio_edge_irq_v2.sv
// Avalon-MM PIO with per-bit rise/fall edge capture and level interrupt.
// Define PIO_DEBOUNCE_EN to add a shared prescaler and per-bit debounce filter.
module pio_edge_irq_v2
  import pio_v2_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_DIV = 1000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic [WIDTH-1:0] out_port,
  output logic             irq
);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("pio_edge_irq_v2: WIDTH out of range");
  end
  if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_sync
    $error("pio_edge_irq_v2: SYNC_STAGES out of range");
  end

  logic             wr_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] data_out, irq_mask, edge_capture, rise_en, fall_en;
  logic [WIDTH-1:0] filt, prev, edge_det, clr_mask;
  logic [31:0]      rd_next;
  logic             unused_wdata;

  assign wr_en        = chipselect & ~write_n;
  assign wdata        = writedata[WIDTH-1:0];
  assign unused_wdata = &{1'b0, writedata};

`ifdef PIO_DEBOUNCE_EN
  logic [15:0] div_cnt;
  logic        tick;

  assign tick = (div_cnt == 16'(DEBOUNCE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  div_cnt <= '0;
    else if (tick) div_cnt <= '0;
    else           div_cnt <= div_cnt + 16'd1;
  end
`else
  localparam int unused_debounce_div = DEBOUNCE_DIV;
`endif

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_bit_sync #(
      .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
      .clk    (clk),
      .reset_n(reset_n),
      .din    (in_port[i]),
`ifdef PIO_DEBOUNCE_EN
      .tick   (tick),
`endif
      .filt   (filt[i]),
      .prev   (prev[i])
    );
  end

  assign edge_det = (filt & ~prev & rise_en) | (~filt & prev & fall_en);
  assign clr_mask = (wr_en && addr_e'(address) == ADDR_EDGE_CAPTURE) ? wdata : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_out     <= '0;
      irq_mask     <= '0;
      edge_capture <= '0;
      rise_en      <= '0;
      fall_en      <= '0;
    end else begin
      // NOTE: the new edge is ORed in after the clear, so a same-cycle detect wins.
      edge_capture <= (edge_capture & ~clr_mask) | edge_det;
      if (wr_en) begin
        unique case (addr_e'(address))
          ADDR_DATA_OUT: data_out <= wdata;
          ADDR_IRQ_MASK: irq_mask <= wdata;
          ADDR_RISE_EN:  rise_en  <= wdata;
          ADDR_FALL_EN:  fall_en  <= wdata;
          ADDR_OUT_SET:  data_out <= data_out | wdata;
          ADDR_OUT_CLR:  data_out <= data_out & ~wdata;
          default: ;
        endcase
      end
    end
  end

  // NOTE: rd_next gets a full default before the case, so no latch can be inferred.
  always_comb begin
    rd_next = '0;
    unique case (addr_e'(address))
      ADDR_DATA_IN:      rd_next[WIDTH-1:0] = filt;
      ADDR_DATA_OUT:     rd_next[WIDTH-1:0] = data_out;
      ADDR_IRQ_MASK:     rd_next[WIDTH-1:0] = irq_mask;
      ADDR_EDGE_CAPTURE: rd_next[WIDTH-1:0] = edge_capture;
      ADDR_RISE_EN:      rd_next[WIDTH-1:0] = rise_en;
      ADDR_FALL_EN:      rd_next[WIDTH-1:0] = fall_en;
      default:           rd_next = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_next;
  end

  assign out_port = data_out;
  assign irq      = |(edge_capture & irq_mask);

endmodule

// File: doc/pio_edge_irq_v2.md
PIO_EDGE_IRQ_V2 -- requirements
Module: pio_edge_irq_v2

Interface
REQ-001 Parameter WIDTH, default 8: number of input and output bits, legal range 1..32.
REQ-002 Parameter SYNC_STAGES, default 2: input synchronizer depth, legal range 2..3.
REQ-003 Parameter DEBOUNCE_DIV, default 1000: debounce sample period in clk cycles, legal range 2..65535; used only with PIO_DEBOUNCE_EN.
REQ-004 clk  in  1  single clock; all logic is rising-edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 address  in  3  Avalon-MM register word address.
REQ-007 chipselect  in  1  slave select.
REQ-008 write_n  in  1  active-low write strobe, qualified by chipselect.
REQ-009 writedata  in  32  write data; bits above WIDTH ignored.
REQ-010 readdata  out  32  registered read data; bits above WIDTH read 0.
REQ-011 in_port  in  WIDTH  asynchronous external inputs.
REQ-012 out_port  out  WIDTH  output register value.
REQ-013 irq  out  1  level interrupt: OR over edge_capture AND irq_mask.

Function
REQ-014 Register map: 0 DATA_IN (RO, filtered input); 1 DATA_OUT (RW); 2 IRQ_MASK (RW); 3 EDGE_CAPTURE (RW1C); 4 RISE_EN (RW); 5 FALL_EN (RW); 6 OUT_SET (WO, reads 0); 7 OUT_CLR (WO, reads 0).
REQ-015 Write = chipselect && !write_n; writes take effect at the same rising edge; no wait states.
REQ-016 readdata is updated every cycle from the address mux, independent of chipselect, giving 1-cycle read latency.
REQ-017 Each in_port bit passes through a SYNC_STAGES-flop synchronizer; one further delay flop (prev) holds the previous filtered value.
REQ-018 Rising edge on bit i = filt[i] & ~prev[i] & RISE_EN[i]; falling edge = ~filt[i] & prev[i] & FALL_EN[i]; both enabled gives any-edge detection.
REQ-019 Without debounce, an in_port change meeting setup sets EDGE_CAPTURE[i] at the (SYNC_STAGES+1)th rising clk edge.
REQ-020 Write to EDGE_CAPTURE clears only the bits written as 1; bits written as 0 are unchanged.
REQ-021 Detect and clear of the same bit in the same cycle: the bit ends set, so no edge is lost.
REQ-022 OUT_SET ORs writedata into DATA_OUT; OUT_CLR clears the bits written as 1; other bits are untouched.
REQ-023 irq is combinational from flops only; it deasserts the cycle after a clearing write or a mask write that removes the last pending bit.
REQ-024 Edges on bits with RISE_EN and FALL_EN both 0 are never captured; changing the enables never creates spurious captures.

Reset
REQ-025 While reset_n is low: DATA_OUT, IRQ_MASK, EDGE_CAPTURE, RISE_EN, synchronizer, prev, readdata and the debounce state all hold 0; FALL_EN holds 0; out_port = 0; irq = 0.
REQ-026 Reset asserted mid-operation aborts everything immediately; pending captures are lost.
REQ-027 Deassertion with in_port high produces no capture, because prev shares the reset value of filt and RISE_EN is 0.

Configuration
REQ-028 Macro PIO_DEBOUNCE_EN defined: a shared prescaler counter wraps at DEBOUNCE_DIV-1 and issues a 1-cycle tick.
REQ-029 With PIO_DEBOUNCE_EN, filt[i] updates only on a tick, and only when the synchronized value was equal on the current and previous tick.
REQ-030 Without PIO_DEBOUNCE_EN: filt = synchronizer output; no counter or tick logic is present, and DEBOUNCE_DIV is unused.

Structure
REQ-031 A shared package pio_v2_pkg holds the address constants (ADDR_DATA_IN..ADDR_OUT_CLR) and the WIDTH and SYNC_STAGES limits.
REQ-032 One sub-module, pio_bit_sync, is instantiated per bit; it contains the synchronizer, the optional debounce filter and the prev flop, and outputs filt and prev.

Verification
REQ-033 Rising-only edge: WIDTH=8, SYNC_STAGES=2, RISE_EN=0x01, MASK=0x01; in_port 0x00 -> 0x01 -> EDGE_CAPTURE=0x01 at the 3rd edge, irq=1, readback of address 3 = 0x01.
REQ-034 Any-edge: RISE_EN=FALL_EN=0x80; in_port 0x80 -> 0x00 -> 0x80 -> 0x80 captured after each transition; write 0x80 to address 3 -> irq=0 next cycle.
REQ-035 Simultaneous events: write 0x01 to address 3 in the same cycle bit 0 detects an edge -> EDGE_CAPTURE[0] remains 1.
REQ-036 Partial clear: EDGE_CAPTURE=0x0F, write 0x05 to address 3 -> 0x0A; MASK=0x05 -> irq=0.
REQ-037 Outputs: DATA_OUT=0xA0, write 0x05 to address 6 -> out_port=0xA5; write 0x81 to address 7 -> out_port=0x24; read address 6 -> 0.
REQ-038 Debounce (PIO_DEBOUNCE_EN, DEBOUNCE_DIV=4): a 3-cycle glitch produces no capture; a level held 12 cycles is captured; reset mid-sequence clears all state.
